// File: rtl/fm_bram_rr_arbiter_pkg.sv
// Shared types and helpers for the feature-map BRAM round-robin arbiter.
// Coordinate-to-address mapping is row-major.
package fm_bram_rr_arbiter_pkg;

  localparam int unsigned DefNClients       = 2;
  localparam int unsigned DefCoordBits      = 8;
  localparam int unsigned DefChannels       = 4;
  localparam int unsigned DefBitsPerChannel = 8;
  localparam int unsigned DefImgWidth       = 32;
  localparam int unsigned DefImgHeight      = 32;
  localparam int unsigned DefRdLatency      = 1;

  typedef struct packed {
    logic [DefCoordBits-1:0] x;
    logic [DefCoordBits-1:0] y;
  } vec2_t;

  function automatic logic [31:0] coord_to_addr(input logic [31:0] x, input logic [31:0] y,
                                                input int unsigned width);
    return y * width + x;
  endfunction

  function automatic logic in_range(input logic [31:0] x, input logic [31:0] y,
                                    input int unsigned width, input int unsigned height);
    return (x < width) && (y < height);
  endfunction

endpackage

// File: rtl/fm_bram_rr_arbiter_if.sv
// Client handshake bus plus the two BRAM ports served by the arbiter.
// slave is the arbiter side; master is the client/BRAM side.
interface fm_bram_rr_arbiter_if #(
  parameter int unsigned N_CLIENTS  = 2,
  parameter int unsigned COORD_BITS = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 10
);
  logic [N_CLIENTS-1:0]            rd_req;
  logic [N_CLIENTS*COORD_BITS-1:0] rd_x;
  logic [N_CLIENTS*COORD_BITS-1:0] rd_y;
  logic [N_CLIENTS-1:0]            rd_gnt;
  logic [N_CLIENTS-1:0]            rd_valid;
  logic [DATA_W-1:0]               rd_data;

  logic [N_CLIENTS-1:0]            wr_req;
  logic [N_CLIENTS*COORD_BITS-1:0] wr_x;
  logic [N_CLIENTS*COORD_BITS-1:0] wr_y;
  logic [N_CLIENTS*DATA_W-1:0]     wr_data;
  logic [N_CLIENTS-1:0]            wr_gnt;

  logic                            bram_en_a;
  logic [ADDR_W-1:0]               bram_addr_a;
  logic [DATA_W-1:0]               bram_dout_a;
  logic                            bram_en_b;
  logic                            bram_we_b;
  logic [ADDR_W-1:0]               bram_addr_b;
  logic [DATA_W-1:0]               bram_din_b;

  modport slave (
    input  rd_req, rd_x, rd_y, wr_req, wr_x, wr_y, wr_data, bram_dout_a,
    output rd_gnt, rd_valid, rd_data, wr_gnt,
    output bram_en_a, bram_addr_a, bram_en_b, bram_we_b, bram_addr_b, bram_din_b
  );

  modport master (
    output rd_req, rd_x, rd_y, wr_req, wr_x, wr_y, wr_data, bram_dout_a,
    input  rd_gnt, rd_valid, rd_data, wr_gnt,
    input  bram_en_a, bram_addr_a, bram_en_b, bram_we_b, bram_addr_b, bram_din_b
  );

endinterface

// File: rtl/fm_bram_rr_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// registered pointer; the pointer moves past the winner only when advance is set.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] win;
  logic [PtrW-1:0] ptr_nxt;

  function automatic int wrap(input int base, input int k);
    return (base + k) % int'(N);
  endfunction

  // Scan from farthest to nearest so the client closest to the pointer wins.
  always_comb begin
    gnt = '0;
    win = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req[wrap(int'(ptr_q), k)]) begin
        gnt                         = '0;
        gnt[wrap(int'(ptr_q), k)]   = 1'b1;
        win                         = PtrW'(wrap(int'(ptr_q), k));
      end
    end
  end

  assign ptr_nxt = (win == PtrW'(N - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && (|gnt)) begin
      ptr_q <= ptr_nxt;
    end
  end

endmodule

// File: rtl/fm_bram_rr_arbiter.sv
// Round-robin front end for the dual-port feature-map BRAM: port A reads with
// tagged return through the BRAM latency, port B writes in the grant cycle.
module fm_bram_rr_arbiter
  import fm_bram_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_CLIENTS        = DefNClients,
  parameter int unsigned COORD_BITS       = DefCoordBits,
  parameter int unsigned CHANNELS         = DefChannels,
  parameter int unsigned BITS_PER_CHANNEL = DefBitsPerChannel,
  parameter int unsigned IMG_WIDTH        = DefImgWidth,
  parameter int unsigned IMG_HEIGHT       = DefImgHeight,
  parameter int unsigned RD_LATENCY       = DefRdLatency,
  parameter int unsigned DATA_W           = CHANNELS * BITS_PER_CHANNEL,
  parameter int unsigned ADDR_W           = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 err_clr,
  output logic                 busy,
  output logic                 oob_err,
  fm_bram_rr_arbiter_if.slave  bus
);

  logic [N_CLIENTS-1:0][ADDR_W-1:0] rd_addr, wr_addr;
  logic [N_CLIENTS-1:0]             rd_ok, wr_ok;

  for (genvar i = 0; i < N_CLIENTS; i++) begin : g_client
    logic [COORD_BITS-1:0] rx, ry, wx, wy;
    assign rx = bus.rd_x[i*COORD_BITS +: COORD_BITS];
    assign ry = bus.rd_y[i*COORD_BITS +: COORD_BITS];
    assign wx = bus.wr_x[i*COORD_BITS +: COORD_BITS];
    assign wy = bus.wr_y[i*COORD_BITS +: COORD_BITS];
    assign rd_addr[i] = ADDR_W'(coord_to_addr(32'(rx), 32'(ry), IMG_WIDTH));
    assign wr_addr[i] = ADDR_W'(coord_to_addr(32'(wx), 32'(wy), IMG_WIDTH));
    assign rd_ok[i]   = in_range(32'(rx), 32'(ry), IMG_WIDTH, IMG_HEIGHT);
    assign wr_ok[i]   = in_range(32'(wx), 32'(wy), IMG_WIDTH, IMG_HEIGHT);
  end

  logic [N_CLIENTS-1:0] rd_req_en, wr_req_en, rd_cand, wr_cand, rd_gnt, wr_gnt;
  logic                 rd_adv, wr_adv, collision, oob_set;
  logic [ADDR_W-1:0]    rd_sel_addr, wr_sel_addr;
  logic                 rd_sel_ok, wr_sel_ok;
  logic [DATA_W-1:0]    wr_sel_data;

  assign rd_req_en = bus.rd_req & {N_CLIENTS{enable}};
  assign wr_req_en = bus.wr_req & {N_CLIENTS{enable}};

  rr_arbiter #(.N(N_CLIENTS)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_req_en),
    .advance (rd_adv),
    .gnt     (rd_cand)
  );

  rr_arbiter #(.N(N_CLIENTS)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_req_en),
    .advance (wr_adv),
    .gnt     (wr_cand)
  );

  always_comb begin
    rd_sel_addr = '0;
    rd_sel_ok   = 1'b0;
    wr_sel_addr = '0;
    wr_sel_ok   = 1'b0;
    wr_sel_data = '0;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      if (rd_cand[i]) begin
        rd_sel_addr = rd_addr[i];
        rd_sel_ok   = rd_ok[i];
      end
      if (wr_cand[i]) begin
        wr_sel_addr = wr_addr[i];
        wr_sel_ok   = wr_ok[i];
        wr_sel_data = bus.wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Same-address read/write: write goes first, read retries next cycle.
  assign collision = (|rd_cand) && (|wr_cand) && rd_sel_ok && wr_sel_ok &&
                     (rd_sel_addr == wr_sel_addr);
  assign rd_gnt    = collision ? '0 : rd_cand;
  assign wr_gnt    = wr_cand;
  assign rd_adv    = |rd_gnt;
  assign wr_adv    = |wr_gnt;
  assign oob_set   = (rd_adv && !rd_sel_ok) || (wr_adv && !wr_sel_ok);

  assign bus.rd_gnt      = rd_gnt;
  assign bus.wr_gnt      = wr_gnt;
  assign bus.bram_en_a   = rd_adv && rd_sel_ok;
  assign bus.bram_addr_a = rd_sel_addr;
  assign bus.bram_en_b   = wr_adv && wr_sel_ok;
  assign bus.bram_we_b   = wr_adv && wr_sel_ok;
  assign bus.bram_addr_b = wr_sel_addr;
  assign bus.bram_din_b  = wr_sel_data;

  logic [RD_LATENCY-1:0][N_CLIENTS-1:0] tag_q;
  logic [RD_LATENCY-1:0]                oob_q;  // out-of-range reads return zero data
  logic                                 err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
      oob_q <= '0;
      err_q <= 1'b0;
    end else begin
      tag_q[0] <= rd_gnt;
      oob_q[0] <= rd_adv && !rd_sel_ok;
      for (int s = 1; s < int'(RD_LATENCY); s++) begin
        tag_q[s] <= tag_q[s-1];
        oob_q[s] <= oob_q[s-1];
      end
      if (oob_set) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.rd_valid = tag_q[RD_LATENCY-1];
  assign bus.rd_data  = ((|tag_q[RD_LATENCY-1]) && !oob_q[RD_LATENCY-1]) ?
                        bus.bram_dout_a : '0;
  assign busy         = (|tag_q) || rd_adv || wr_adv;
  assign oob_err      = err_q;

endmodule

// File: tb/tb_fm_bram_rr_arbiter.sv
// Directed bench for fm_bram_rr_arbiter with a 2-cycle BRAM model and a
// scoreboard of expected read returns.
module tb_fm_bram_rr_arbiter;
  import fm_bram_rr_arbiter_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned L  = 2;
  localparam int unsigned W  = 32;
  localparam int unsigned H  = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic err_clr = 1'b0;
  logic busy, oob_err;

  fm_bram_rr_arbiter_if #(.N_CLIENTS(N), .COORD_BITS(8), .DATA_W(DW), .ADDR_W(AW)) bus ();

  fm_bram_rr_arbiter #(
    .N_CLIENTS        (N),
    .COORD_BITS       (8),
    .CHANNELS         (4),
    .BITS_PER_CHANNEL (8),
    .IMG_WIDTH        (W),
    .IMG_HEIGHT       (H),
    .RD_LATENCY       (L)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .err_clr (err_clr),
    .busy    (busy),
    .oob_err (oob_err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: port A has two register stages, port B writes on the edge.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] pipe1 = '0;
  logic [DW-1:0] pipe2 = '0;
  always @(posedge clk) begin
    if (bus.bram_en_a) pipe1 <= mem[bus.bram_addr_a];
    pipe2 <= pipe1;
    if (bus.bram_en_b && bus.bram_we_b) mem[bus.bram_addr_b] <= bus.bram_din_b;
  end
  assign bus.bram_dout_a = pipe2;

  function automatic logic [DW-1:0] pat(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
    int            due;
  } rexp_t;
  rexp_t sb[$];

  task automatic expect_rd(input int c, input logic [DW-1:0] d);
    rexp_t e;
    e.tag  = N'(1 << c);
    e.data = d;
    e.due  = cyc + int'(L);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    rexp_t e;
    if (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("rd_valid", 64'(bus.rd_valid), 64'(e.tag));
      check("rd_data", 64'(bus.rd_data), 64'(e.data));
    end else if (bus.rd_valid != '0) begin
      check("spurious rd_valid", 64'(bus.rd_valid), 64'(0));
    end
  end

  function automatic vec2_t mk(input int x, input int y);
    vec2_t v;
    v.x = 8'(x);
    v.y = 8'(y);
    return v;
  endfunction

  task automatic set_rd(input int c, input vec2_t p);
    bus.rd_x[c*8 +: 8] = p.x;
    bus.rd_y[c*8 +: 8] = p.y;
  endtask

  task automatic set_wr(input int c, input vec2_t p, input logic [DW-1:0] d);
    bus.wr_x[c*8 +: 8]     = p.x;
    bus.wr_y[c*8 +: 8]     = p.y;
    bus.wr_data[c*DW +: DW] = d;
  endtask

  // Reference round-robin pick: nearest requester at or above ptr.
  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < int'(N); k++) begin
      if (req[(ptr + k) % int'(N)]) return (ptr + k) % int'(N);
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rptr = 0;
  int wptr = 0;
  int w;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = pat(a);
    bus.rd_req = '0; bus.rd_x = '0; bus.rd_y = '0;
    bus.wr_req = '0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_data = '0;

    // Reset state
    @(negedge clk);
    check("rst rd_gnt", 64'(bus.rd_gnt), 0);
    check("rst wr_gnt", 64'(bus.wr_gnt), 0);
    check("rst rd_valid", 64'(bus.rd_valid), 0);
    check("rst rd_data", 64'(bus.rd_data), 0);
    check("rst en_a", 64'(bus.bram_en_a), 0);
    check("rst en_b", 64'(bus.bram_en_b), 0);
    check("rst busy", 64'(busy), 0);
    check("rst oob_err", 64'(oob_err), 0);
    step(); step();
    rst_n = 1'b1;
    enable = 1'b1;

    // Single read of (3,1)
    set_rd(0, mk(3, 1));
    bus.rd_req = 2'b01;
    @(negedge clk);
    check("t1 rd_gnt", 64'(bus.rd_gnt), 64'(2'b01));
    check("t1 en_a", 64'(bus.bram_en_a), 1);
    check("t1 addr_a", 64'(bus.bram_addr_a), 35);
    check("t1 busy", 64'(busy), 1);
    expect_rd(0, pat(35));
    rptr = 1;
    step();
    bus.rd_req = '0;
    repeat (3) step();

    // Both clients hold reads for six cycles
    set_rd(0, mk(7, 2));
    set_rd(1, mk(9, 4));
    bus.rd_req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w = pick(2'b11, rptr);
      check("t2 rd_gnt", 64'(bus.rd_gnt), 64'(1 << w));
      expect_rd(w, pat(w == 0 ? 2 * 32 + 7 : 4 * 32 + 9));
      rptr = (w + 1) % int'(N);
      step();
    end
    bus.rd_req = '0;
    repeat (3) step();

    // Read/write collision on (5,5)
    set_rd(0, mk(5, 5));
    set_wr(1, mk(5, 5), 32'h1234_5678);
    bus.rd_req = 2'b01;
    bus.wr_req = 2'b10;
    @(negedge clk);
    check("t3 wr_gnt", 64'(bus.wr_gnt), 64'(2'b10));
    check("t3 rd_gnt", 64'(bus.rd_gnt), 0);
    check("t3 en_a", 64'(bus.bram_en_a), 0);
    check("t3 we_b", 64'(bus.bram_we_b), 1);
    check("t3 addr_b", 64'(bus.bram_addr_b), 165);
    check("t3 din_b", 64'(bus.bram_din_b), 64'h1234_5678);
    wptr = 0;
    step();
    bus.wr_req = '0;
    @(negedge clk);
    check("t3 retry rd_gnt", 64'(bus.rd_gnt), 64'(2'b01));
    check("t3 retry addr_a", 64'(bus.bram_addr_a), 165);
    expect_rd(0, 32'h1234_5678);
    rptr = 1;
    step();
    bus.rd_req = '0;
    repeat (3) step();

    // Out-of-range read and sticky error flag
    set_rd(1, mk(40, 0));
    bus.rd_req = 2'b10;
    @(negedge clk);
    check("t4 rd_gnt", 64'(bus.rd_gnt), 64'(2'b10));
    check("t4 en_a", 64'(bus.bram_en_a), 0);
    check("t4 oob before", 64'(oob_err), 0);
    expect_rd(1, '0);
    rptr = 0;
    step();
    bus.rd_req = '0;
    @(negedge clk);
    check("t4 oob set", 64'(oob_err), 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("t4 oob clr", 64'(oob_err), 0);
    step();
    err_clr = 1'b1;
    bus.rd_req = 2'b10;
    @(negedge clk);
    check("t4 rd_gnt again", 64'(bus.rd_gnt), 64'(2'b10));
    expect_rd(1, '0);
    rptr = 0;
    step();
    err_clr = 1'b0;
    bus.rd_req = '0;
    @(negedge clk);
    check("t4 set beats clr", 64'(oob_err), 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    repeat (2) step();

    // Enable drop with two reads in flight
    set_rd(0, mk(1, 0));
    set_rd(1, mk(2, 0));
    bus.rd_req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      w = pick(2'b11, rptr);
      check("t5 rd_gnt", 64'(bus.rd_gnt), 64'(1 << w));
      expect_rd(w, pat(w == 0 ? 1 : 2));
      rptr = (w + 1) % int'(N);
      step();
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5 no rd_gnt", 64'(bus.rd_gnt), 0);
      check("t5 no en_a", 64'(bus.bram_en_a), 0);
      if (i == 0) check("t5 busy in flight", 64'(busy), 1);
      step();
    end
    enable = 1'b1;
    @(negedge clk);
    w = pick(2'b11, rptr);
    check("t5 resume rd_gnt", 64'(bus.rd_gnt), 64'(1 << w));
    expect_rd(w, pat(w == 0 ? 1 : 2));
    rptr = (w + 1) % int'(N);
    step();
    bus.rd_req = '0;
    repeat (3) step();

    // Reset during an in-flight read
    set_rd(0, mk(1, 1));
    set_wr(0, mk(2, 2), 32'hDEAD_BEEF);
    bus.rd_req = 2'b01;
    bus.wr_req = 2'b01;
    @(negedge clk);
    check("t6 rd_gnt", 64'(bus.rd_gnt), 64'(2'b01));
    check("t6 wr_gnt", 64'(bus.wr_gnt), 64'(2'b01));
    step();
    bus.rd_req = '0;
    bus.wr_req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6 rst rd_valid", 64'(bus.rd_valid), 0);
    check("t6 rst busy", 64'(busy), 0);
    check("t6 rst rd_data", 64'(bus.rd_data), 0);
    step(); step();
    rst_n = 1'b1;
    repeat (3) step();
    set_rd(0, mk(4, 4));
    set_rd(1, mk(6, 6));
    set_wr(0, mk(8, 8), 32'h0000_0A0A);
    set_wr(1, mk(9, 9), 32'h0000_0B0B);
    bus.rd_req = 2'b11;
    bus.wr_req = 2'b11;
    @(negedge clk);
    check("t6 rd ptr reset", 64'(bus.rd_gnt), 64'(2'b01));
    check("t6 wr ptr reset", 64'(bus.wr_gnt), 64'(2'b01));
    expect_rd(0, pat(4 * 32 + 4));
    step();
    bus.rd_req = '0;
    bus.wr_req = '0;
    repeat (4) step();

    check("scoreboard drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
